// File: rtl/rv_lsu_pkg.sv
// rv_lsu_pkg: FSM states, funct3 size/sign encodings and exception codes shared by the LSU.
package rv_lsu_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {EXC_NONE, EXC_MISALIGNED, EXC_ILLEGAL, EXC_ACCESS_FAULT} exc_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    function automatic logic is_illegal(input logic [2:0] f, input logic st, input int xlen);
        return f == 3'b111 || (st && f[2]) || (xlen == 32 && (f == F3_D || f == F3_WU));
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f, input logic [2:0] a);
        return (f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a[1:0] != 2'b00) ||
               (f[1:0] == 2'b11 && a != 3'b000);
    endfunction

endpackage

// File: rtl/rv_lsu_if.sv
// rv_lsu_if: data-memory bus between the LSU (master) and the memory (slave).
interface rv_lsu_if #(parameter int XLEN = 32) ();

    logic                data_mem_request;
    logic                data_mem_we_re;
    logic [XLEN/8-1:0]   data_mem_mask;
    logic [XLEN-1:0]     dm_addr;
    logic [XLEN-1:0]     dm_store_data_out;
    logic [XLEN-1:0]     dm_load_data_in;
    logic                dm_valid;

    modport master (
        output data_mem_request, data_mem_we_re, data_mem_mask, dm_addr, dm_store_data_out,
        input  dm_load_data_in, dm_valid
    );

    modport slave (
        input  data_mem_request, data_mem_we_re, data_mem_mask, dm_addr, dm_store_data_out,
        output dm_load_data_in, dm_valid
    );

endinterface

// File: rtl/rv_lsu_align.sv
// rv_lsu_align: byte-lane mask, store data shift and load extract/extend.
module rv_lsu_align import rv_lsu_pkg::*; #(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OW = $clog2(NB)
) (
    input  logic [2:0]      i_funct3,
    input  logic [OW-1:0]   i_off,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [2:0]      i_ld_funct3,
    input  logic [OW-1:0]   i_ld_off,
    input  logic [XLEN-1:0] i_load_raw,
    output logic [NB-1:0]   o_mask,
    output logic [XLEN-1:0] o_store_data,
    output logic [XLEN-1:0] o_load_data
);

    logic [NB-1:0]   w_base;
    logic [XLEN-1:0] w_sized;
    logic [XLEN-1:0] w_sh;

    assign w_base = i_funct3[1:0] == 2'b00 ? NB'(1)  :
                    i_funct3[1:0] == 2'b01 ? NB'(3)  :
                    i_funct3[1:0] == 2'b10 ? NB'(15) : '1;
    assign o_mask = w_base << i_off;

    // trim to access size first so lanes outside the mask are driven 0
    assign w_sized = i_funct3[1:0] == 2'b00 ? XLEN'(i_store_data[7:0])  :
                     i_funct3[1:0] == 2'b01 ? XLEN'(i_store_data[15:0]) :
                     i_funct3[1:0] == 2'b10 ? XLEN'(i_store_data[31:0]) : i_store_data;
    assign o_store_data = w_sized << {i_off, 3'b000};

    assign w_sh = i_load_raw >> {i_ld_off, 3'b000};
    assign o_load_data = i_ld_funct3 == F3_B  ? XLEN'($signed(w_sh[7:0]))  :
                         i_ld_funct3 == F3_H  ? XLEN'($signed(w_sh[15:0])) :
                         i_ld_funct3 == F3_W  ? XLEN'($signed(w_sh[31:0])) :
                         i_ld_funct3 == F3_BU ? XLEN'(w_sh[7:0])           :
                         i_ld_funct3 == F3_HU ? XLEN'(w_sh[15:0])          :
                         i_ld_funct3 == F3_WU ? XLEN'(w_sh[31:0])          : w_sh;

endmodule

// File: rtl/rv_lsu.sv
// rv_lsu: load/store unit; validates, issues and tracks one data-memory access at a time.
module rv_lsu import rv_lsu_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_lsu_valid,
    input  logic            i_load,
    input  logic            i_store,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_store_data,
    output logic            o_stall,
    output logic [XLEN-1:0] o_load_data,
    output logic            o_done,
    output logic            o_misaligned,
    output logic            o_illegal,
    output logic            o_access_fault,
    rv_lsu_if.master        dm
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_funct3;
    logic [OW-1:0]   r_off;
    logic            r_req;
    logic            r_we;
    logic [NB-1:0]   r_mask;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_ldata;
    logic            r_done;
    logic            r_fault;

    exc_t            w_exc;
    logic            w_op;
    logic            w_accept;
    logic [NB-1:0]   w_mask;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_ldata;

    assign w_op     = i_lsu_valid && (i_load ^ i_store) && r_state == IDLE;
    assign w_exc    = is_illegal(i_funct3, i_store, XLEN)     ? EXC_ILLEGAL    :
                      is_misaligned(i_funct3, i_addr[2:0])    ? EXC_MISALIGNED : EXC_NONE;
    assign w_accept = w_op && w_exc == EXC_NONE;

    rv_lsu_align #(.XLEN(XLEN)) u_align (
        .i_funct3     (i_funct3),
        .i_off        (i_addr[OW-1:0]),
        .i_store_data (i_store_data),
        .i_ld_funct3  (r_funct3),
        .i_ld_off     (r_off),
        .i_load_raw   (dm.dm_load_data_in),
        .o_mask       (w_mask),
        .o_store_data (w_wdata),
        .o_load_data  (w_ldata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_funct3 <= '0;
            r_off    <= '0;
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            r_mask   <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_ldata  <= '0;
            r_done   <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                IDLE: if (w_accept) begin
                    r_state  <= BUSY;
                    r_cnt    <= '0;
                    r_req    <= 1'b1;
                    r_we     <= i_store;
                    r_mask   <= w_mask;
                    r_addr   <= {i_addr[XLEN-1:OW], OW'(0)};
                    r_wdata  <= w_wdata;
                    r_funct3 <= i_funct3;
                    r_off    <= i_addr[OW-1:0];
                end
                BUSY: if (dm.dm_valid) begin
                    r_state <= RESP;
                    r_req   <= 1'b0;
                    r_done  <= 1'b1;
                    if (!r_we) r_ldata <= w_ldata;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_fault <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall           = w_accept || r_state == BUSY;
    assign o_load_data       = r_ldata;
    assign o_done            = r_done;
    assign o_illegal         = w_op && w_exc == EXC_ILLEGAL;
    assign o_misaligned      = w_op && w_exc == EXC_MISALIGNED;
    assign o_access_fault    = r_fault;
    assign dm.data_mem_request  = r_req;
    assign dm.data_mem_we_re    = r_we;
    assign dm.data_mem_mask     = r_mask;
    assign dm.dm_addr           = r_addr;
    assign dm.dm_store_data_out = r_wdata;

endmodule

// File: tb/tb_rv_lsu.sv
// tb_rv_lsu: directed checks of a 32-bit (TIMEOUT=4) and a 64-bit LSU sharing one stimulus set.
module tb_rv_lsu;
    import rv_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel, v32, v64, ld, st, dmv;
    logic [2:0]  f;
    logic [63:0] a, sd, rd;

    logic        stall32, done32, mis32, ill32, af32;
    logic        stall64, done64, mis64, ill64, af64;
    logic [31:0] ld32;
    logic [63:0] ld64;

    rv_lsu_if #(.XLEN(32)) m32 ();
    rv_lsu_if #(.XLEN(64)) m64 ();
    assign m32.dm_load_data_in = rd[31:0];
    assign m32.dm_valid        = dmv;
    assign m64.dm_load_data_in = rd;
    assign m64.dm_valid        = dmv;

    rv_lsu #(.XLEN(32), .TIMEOUT(4)) u32 (
        .clk(clk), .rst_n(rst_n), .i_lsu_valid(v32), .i_load(ld), .i_store(st), .i_funct3(f),
        .i_addr(a[31:0]), .i_store_data(sd[31:0]), .o_stall(stall32), .o_load_data(ld32),
        .o_done(done32), .o_misaligned(mis32), .o_illegal(ill32), .o_access_fault(af32), .dm(m32)
    );

    rv_lsu #(.XLEN(64), .TIMEOUT(16)) u64 (
        .clk(clk), .rst_n(rst_n), .i_lsu_valid(v64), .i_load(ld), .i_store(st), .i_funct3(f),
        .i_addr(a), .i_store_data(sd), .o_stall(stall64), .o_load_data(ld64),
        .o_done(done64), .o_misaligned(mis64), .o_illegal(ill64), .o_access_fault(af64), .dm(m64)
    );

    logic        o_stall, o_done, o_mis, o_ill, o_af, o_req, o_we;
    logic [7:0]  o_mask;
    logic [63:0] o_addr, o_sd, o_ld;

    always_comb begin
        o_stall = sel ? stall64 : stall32;
        o_done  = sel ? done64  : done32;
        o_mis   = sel ? mis64   : mis32;
        o_ill   = sel ? ill64   : ill32;
        o_af    = sel ? af64    : af32;
        o_req   = sel ? m64.data_mem_request : m32.data_mem_request;
        o_we    = sel ? m64.data_mem_we_re   : m32.data_mem_we_re;
        o_mask  = sel ? m64.data_mem_mask    : {4'b0, m32.data_mem_mask};
        o_addr  = sel ? m64.dm_addr          : {32'b0, m32.dm_addr};
        o_sd    = sel ? m64.dm_store_data_out : {32'b0, m32.dm_store_data_out};
        o_ld    = sel ? ld64                 : {32'b0, ld32};
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic vv, input logic l, input logic t, input logic [2:0] fn,
                         input logic [63:0] ad, input logic [63:0] data);
        v32 = vv & ~sel;
        v64 = vv & sel;
        ld  = l;
        st  = t;
        f   = fn;
        a   = ad;
        sd  = data;
    endtask

    task automatic run(input string tg, input logic t, input logic [2:0] fn, input logic [63:0] ad,
                       input logic [63:0] data, input logic [63:0] resp, input logic [7:0] em,
                       input logic [63:0] ea, input logic [63:0] esd, input logic [63:0] eld);
        drive(1'b1, ~t, t, fn, ad, data);
        #1;
        check({tg, "_accept_stall"}, o_stall, 1);
        check({tg, "_accept_exc"}, {o_ill, o_mis}, 0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 64'h0, 64'h0);
        dmv = 1'b1;
        rd  = resp;
        #1;
        check({tg, "_req"}, o_req, 1);
        check({tg, "_we"}, o_we, t);
        check({tg, "_mask"}, o_mask, em);
        check({tg, "_addr"}, o_addr, ea);
        check({tg, "_wdata"}, o_sd, esd);
        check({tg, "_busy_stall"}, o_stall, 1);
        tick;
        dmv = 1'b0;
        #1;
        check({tg, "_done"}, o_done, 1);
        check({tg, "_resp_stall"}, o_stall, 0);
        check({tg, "_resp_req"}, o_req, 0);
        if (!t) check({tg, "_ldata"}, o_ld, eld);
        tick;
        #1;
        check({tg, "_done_pulse"}, o_done, 0);
    endtask

    task automatic exc(input string tg, input logic l, input logic t, input logic [2:0] fn,
                       input logic [63:0] ad, input logic ei, input logic em);
        drive(1'b1, l, t, fn, ad, 64'h0);
        #1;
        check({tg, "_illegal"}, o_ill, ei);
        check({tg, "_misaligned"}, o_mis, em);
        check({tg, "_stall"}, o_stall, 0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 64'h0, 64'h0);
        #1;
        check({tg, "_no_req"}, o_req, 0);
        check({tg, "_no_pulse"}, {o_ill, o_mis}, 0);
    endtask

    initial begin
        int nreq, nf, nd, fat;
        sel = 1'b0;
        dmv = 1'b0;
        rd  = '0;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 64'h0, 64'h0);
        repeat (2) @(posedge clk);
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_req", o_req, 0);
            check("rst_we", o_we, 0);
            check("rst_mask", o_mask, 0);
            check("rst_addr", o_addr, 0);
            check("rst_wdata", o_sd, 0);
            check("rst_ldata", o_ld, 0);
            check("rst_pulses", {o_done, o_mis, o_ill, o_af, o_stall}, 0);
        end
        rst_n = 1'b1;
        sel = 1'b0;
        tick;

        run("sb",  1, F3_B,  64'h103, 64'h123456AB, 64'h0,        8'h08, 64'h100, 64'hAB000000, 64'h0);
        run("lh",  0, F3_H,  64'h102, 64'h0,        64'h80010000, 8'h0C, 64'h100, 64'h0, 64'hFFFF8001);
        run("lhu", 0, F3_HU, 64'h102, 64'h0,        64'h80010000, 8'h0C, 64'h100, 64'h0, 64'h00008001);
        run("lb",  0, F3_B,  64'h101, 64'h0,        64'h00008000, 8'h02, 64'h100, 64'h0, 64'hFFFFFF80);
        run("lbu", 0, F3_BU, 64'h103, 64'h0,        64'hF1000000, 8'h08, 64'h100, 64'h0, 64'h000000F1);
        run("sh",  1, F3_H,  64'h102, 64'hDEADBEEF, 64'h0,        8'h0C, 64'h100, 64'hBEEF0000, 64'h0);
        run("sw",  1, F3_W,  64'h104, 64'hCAFEF00D, 64'h0,        8'h0F, 64'h104, 64'hCAFEF00D, 64'h0);
        run("lw",  0, F3_W,  64'h010, 64'h0,        64'h87654321, 8'h0F, 64'h010, 64'h0, 64'h87654321);

        exc("lw_mis",   1, 0, F3_W,   64'h101, 0, 1);
        exc("lh_mis",   1, 0, F3_H,   64'h103, 0, 1);
        exc("ld32_ill", 1, 0, F3_D,   64'h100, 1, 0);
        exc("lwu32_ill",1, 0, F3_WU,  64'h100, 1, 0);
        exc("sbu_ill",  0, 1, F3_BU,  64'h100, 1, 0);
        exc("f7_ill",   1, 0, 3'b111, 64'h100, 1, 0);
        exc("prio_ill", 1, 0, 3'b111, 64'h101, 1, 0);
        exc("noop_both",1, 1, 3'b111, 64'h101, 0, 0);
        exc("noop_none",0, 0, F3_W,   64'h101, 0, 0);

        dmv = 1'b1;
        tick;
        dmv = 1'b0;
        #1;
        check("stray_valid_done", o_done, 0);
        check("stray_valid_req", o_req, 0);

        drive(1'b1, 1'b1, 1'b0, F3_W, 64'h200, 64'h0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 64'h0, 64'h0);
        nreq = 0; nf = 0; nd = 0; fat = -1;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (o_req) nreq++;
            if (o_af) begin nf++; fat = i; end
            if (o_done) nd++;
            tick;
        end
        check("to_req_cycles", 64'(nreq), 4);
        check("to_fault_count", 64'(nf), 1);
        check("to_fault_cycle", 64'(fat), 4);
        check("to_no_done", 64'(nd), 0);
        check("to_idle_stall", o_stall, 0);

        drive(1'b1, 1'b1, 1'b0, F3_W, 64'h200, 64'h0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 64'h0, 64'h0);
        repeat (3) tick;
        dmv = 1'b1;
        rd  = 64'h11223344;
        tick;
        dmv = 1'b0;
        #1;
        check("last_valid_done", o_done, 1);
        check("last_valid_fault", o_af, 0);
        check("last_valid_ldata", o_ld, 64'h11223344);
        tick;
        #1;
        check("last_valid_nofault", o_af, 0);

        drive(1'b1, 1'b0, 1'b1, F3_W, 64'h300, 64'h55AA55AA);
        tick;
        drive(1'b0, 1'b0, 1'b0, 3'b0, 64'h0, 64'h0);
        tick;
        #1;
        check("rstmid_req_before", o_req, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_req", o_req, 0);
        check("rstmid_mask", o_mask, 0);
        check("rstmid_addr", o_addr, 0);
        check("rstmid_stall", o_stall, 0);
        tick;
        check("rstmid_done", o_done, 0);
        rst_n = 1'b1;
        tick;
        #1;
        check("rstmid_after_done", o_done, 0);
        check("rstmid_after_req", o_req, 0);
        run("sw_after_rst", 1, F3_W, 64'h304, 64'h0BADF00D, 64'h0, 8'h0F, 64'h304, 64'h0BADF00D, 64'h0);

        sel = 1'b1;
        #1;
        run("ld64",  0, F3_D,  64'h008, 64'h0, 64'h1122334455667788, 8'hFF, 64'h008, 64'h0, 64'h1122334455667788);
        run("lw64",  0, F3_W,  64'h004, 64'h0, 64'h8000000100000000, 8'hF0, 64'h000, 64'h0, 64'hFFFFFFFF80000001);
        run("lwu64", 0, F3_WU, 64'h004, 64'h0, 64'h8000000100000000, 8'hF0, 64'h000, 64'h0, 64'h0000000080000001);
        run("lh64",  0, F3_H,  64'h006, 64'h0, 64'h7FFF000000000000, 8'hC0, 64'h000, 64'h0, 64'h0000000000007FFF);
        run("sb64",  1, F3_B,  64'h007, 64'h123456789ABCDE5A, 64'h0, 8'h80, 64'h000, 64'h5A00000000000000, 64'h0);
        run("sd64",  1, F3_D,  64'h010, 64'h0102030405060708, 64'h0, 8'hFF, 64'h010, 64'h0102030405060708, 64'h0);
        exc("ld64_mis", 1, 0, F3_D, 64'h004, 0, 1);
        exc("sw64_mis", 0, 1, F3_W, 64'h002, 0, 1);
        exc("sd64_ill", 0, 1, 3'b111, 64'h000, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv_lsu.md
RV_LSU -- requirements
Module: rv_lsu

Interface
REQ-001 Parameter XLEN, default 32, data/address width; the only legal values are 32 and 64.
REQ-002 Parameter TIMEOUT, default 16, maximum BUSY cycles before an access fault; minimum legal value 2.
REQ-003 Parameter NB, derived as XLEN/8, number of byte lanes.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 lsu_valid  in  1  execute stage presents a memory operation this cycle.
REQ-007 load / store  in  1 each  operation type from decode.
REQ-008 funct3  in  3  size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
REQ-009 addr  in  XLEN  effective address (ALU result).
REQ-010 store_data  in  XLEN  rs2 value, right-aligned.
REQ-011 stall  out  1  hold fetch/decode; pipeline must not advance.
REQ-012 load_data  out  XLEN  extended load result, valid while done=1.
REQ-013 done  out  1  one-cycle pulse; access completed.
REQ-014 misaligned / illegal / access_fault  out  1 each  one-cycle exception pulses.
REQ-015 data_mem_request  out  1; data_mem_we_re  out  1 (1=write, 0=read); data_mem_mask  out  NB; DM_addr  out  XLEN (lane-aligned, low bits zero); DM_store_data_out  out  XLEN.
REQ-016 DM_load_data_in  in  XLEN; DM_valid  in  1  memory response strobe.

Function
REQ-017 FSM states: IDLE, BUSY, RESP.
REQ-018 IDLE accepts when lsu_valid=1 and exactly one of load/store=1; load=store=1 or both 0 is a no-op with no pulse.
REQ-019 Illegal: funct3=111; store with funct3[2]=1; XLEN=32 with funct3 011/110. illegal pulses combinationally in the same cycle, no request issued, stall=0, state stays IDLE.
REQ-020 Misaligned: H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0. misaligned pulses in the same cycle, no request, stall=0; when both conditions apply, illegal has priority.
REQ-021 Legal accepted access: addr, mask, shifted store data, funct3 and offset are registered; go to BUSY; stall=1 in the accept cycle.
REQ-022 In BUSY, data_mem_request=1 and DM_addr/mask/we_re/store data are held stable; stall=1.
REQ-023 In BUSY with DM_valid=1: for a load, capture the extended DM_load_data_in into load_data; go to RESP. DM_valid seen outside BUSY is ignored.
REQ-024 In RESP: done=1 for one cycle, stall=0, load_data stable; next state IDLE. A new accept in the RESP cycle is not allowed; lsu_valid is sampled again only in IDLE.
REQ-025 Minimum latency: accept in cycle 0, request in cycle 1, DM_valid in cycle 1, done in cycle 2.
REQ-026 Timeout counter clears on entry to BUSY. If TIMEOUT cycles elapse in BUSY without DM_valid, access_fault pulses for one cycle, request drops, and the state returns to IDLE with no done. DM_valid in the final cycle wins over the timeout.
REQ-027 Mask: B gives 1 lane, H 2, W 4, D 8, shifted left by the byte offset addr[log2(NB)-1:0].
REQ-028 Store data is shifted left by 8×offset; unused lanes are don't-care but driven 0.
REQ-029 Load data is shifted right by 8×offset, then sign-extended (B/H/W) or zero-extended (BU/HU/WU) to XLEN; D is passed through.

Reset
REQ-030 rst=0 immediately forces IDLE, asynchronously, including mid-BUSY; any pending access is abandoned.
REQ-031 During reset: request=0, we_re=0, mask=0, DM_addr=0, DM_store_data_out=0, load_data=0, done/exception pulses=0, timeout counter=0.

Structure
REQ-032 Package rv_lsu_pkg holds the state enum, the funct3 size/sign constants, and the exception encodings.
REQ-033 One combinational sub-module, rv_lsu_align, computes the mask, store shift and load extract/extend; the FSM stays in rv_lsu.

Verification
REQ-034 XLEN=32: store SB, addr=0x103, data=0xAB, DM_valid on cycle 1 -> mask=4'b1000, DM_addr=0x100, DM_store_data_out=0xAB000000, we_re=1, done on cycle 2.
REQ-035 XLEN=32: load LH, addr=0x102, DM_load_data_in=0x8001_0000 -> load_data=0xFFFF8001; LHU, same inputs -> 0x00008001.
REQ-036 LW with addr=0x101 -> misaligned pulse; no request; stall=0.
REQ-037 XLEN=64: LD, addr=0x8, data=0x1122334455667788 -> mask=8'hFF, load_data equal to the input; funct3=011 at XLEN=32 -> illegal pulse.
REQ-038 TIMEOUT=4, DM_valid never asserted -> request high for exactly 4 cycles, then access_fault pulse, IDLE, no done.
REQ-039 rst asserted in the second BUSY cycle -> request low within the same cycle, no done; a following SW completes normally.
